sdfa_sram_burst: RTL and testbench
==================================

Name: sdfa_sram_burst

Overview:
Parametrised weight SRAM for the LSTM datapath: LANES x W_SIZE_BIT words, DEPTH entries, registered write pipeline.
Adds per-lane write masking, read-after-write bypass of the pending write, and a burst read sequencer that streams consecutive weight rows to the MAC array under valid/ready flow control.
Sits between the weight loader (write side) and the neuron compute engine (read side).

Parameters:
LANES, 8, number of weight lanes per word
W_SIZE_BIT, 14, bits per lane
DEPTH, 256, number of words
ADDR_BIT, 8, address width; must satisfy 2^ADDR_BIT >= DEPTH

Ports:
CLK  input  1  clock, all state on rising edge
RSTN  input  1  asynchronous active-low reset
WE  input  1  active-low write request, captured each cycle
ADDR_WRITE  input  ADDR_BIT  write address
DIN  input  LANES*W_SIZE_BIT  write data; lane i = bits [i*W_SIZE_BIT +: W_SIZE_BIT]
WMASK  input  LANES  per-lane write enable, 1 = lane written
EN_M  input  1  active-low single-read address capture, used only when idle
ADDR  input  ADDR_BIT  single-read address
BURST_START  input  1  start burst read, sampled only in IDLE
BURST_ADDR  input  ADDR_BIT  first burst address
BURST_LEN  input  ADDR_BIT+1  burst length in words
BURST_READY  input  1  consumer accepts DOUT this cycle
DOUT  output  LANES*W_SIZE_BIT  read data
DOUT_VALID  output  1  DOUT is a burst beat
BUSY  output  1  burst in progress
BURST_DONE  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (RSTN low, async): addr_q=0, state IDLE, DOUT_VALID=0, BUSY=0, BURST_DONE=0, we_q=1 (no pending write), addr_write_q/din_q/wmask_q=0. Memory array not reset; DOUT = mem[0] (bypass inactive).
- Write pipeline: cycle N captures WE, ADDR_WRITE, DIN, WMASK. At edge N+1, if we_q==0, lanes with wmask_q=1 of mem[addr_write_q] take din_q; other lanes keep old value. Array contents reflect the write from cycle N+2. Back-to-back writes every cycle are supported. ADDR_WRITE >= DEPTH: write dropped.
- Read: DOUT is combinational from addr_q, bypass-merged.
  - Bypass: if we_q==0 and addr_write_q==addr_q, lanes with wmask_q=1 come from din_q; other lanes come from mem.
  - Net effect: DOUT shows new data one cycle after a write is presented.
- Single read: in IDLE, EN_M==0 loads addr_q<=ADDR. EN_M is ignored while BUSY.
- Burst FSM, two states, IDLE and RUN:
  - IDLE, BURST_START=1, BURST_LEN!=0: addr_q<=BURST_ADDR, cnt<=BURST_LEN, go to RUN. DOUT_VALID=1 and BUSY=1 from the next cycle.
  - IDLE, BURST_START=1, BURST_LEN==0: ignored, no pulse. BURST_START has priority over EN_M in the same cycle.
  - RUN, BURST_READY=0: addr_q, cnt and DOUT hold. DOUT may still change only if a bypassed write to addr_q lands.
  - RUN, BURST_READY=1, cnt>1: cnt-=1; addr_q <= (addr_q==DEPTH-1) ? 0 : addr_q+1.
  - RUN, BURST_READY=1, cnt==1: go to IDLE; DOUT_VALID=0 and BUSY=0 next cycle; BURST_DONE=1 for exactly that next cycle; addr_q holds the last address.
  - BURST_START during RUN is ignored.
  - BURST_LEN > DEPTH is legal; addresses wrap and repeat.
- Writes proceed during bursts. A streamed word reflects any write that has committed or is pending-bypassed at the cycle it is accepted.
- Reset mid-burst aborts immediately: no BURST_DONE, outputs at reset values.
- Throughput: one beat per cycle while BURST_READY=1. First beat is valid one cycle after BURST_START.

Test Plan:
- Lane mask: mem[5] preloaded all lanes 0x0AAA. Write addr 5, DIN lanes = 0x1111*i, WMASK=8'b0000_0101, then single-read 5 -> lanes 0 and 2 new (0x0000, 0x2222), all other lanes 0x0AAA.
- Bypass: EN_M=0 ADDR=9 held. Present write addr 9 data X at cycle N -> DOUT==X at cycle N+1, and still X at N+3 after the bypass retires.
- Burst stall: rows 0..3 hold 0..3. BURST_START addr 0 len 4, BURST_READY toggling 1,0,1,1,0,1 -> beats accepted in order 0,1,2,3; no beat skipped or duplicated; single BURST_DONE pulse after beat 3; BUSY low afterwards.
- Wrap: BURST_ADDR=254, LEN=4, READY=1 -> accepted addresses 254, 255, 0, 1; done pulse at cycle 5.
- Degenerate: BURST_LEN=0 -> BUSY stays 0, no pulse. BURST_START during RUN -> no effect on the current burst. EN_M=0 during RUN -> addr_q unaffected.
- Reset: RSTN low at beat 2 of a len-8 burst -> DOUT_VALID/BUSY/BURST_DONE=0 immediately. After release a new burst runs normally, and memory contents written before reset are intact.

Source files
------------

// File: rtl/sdfa_sram_burst.sv
// Weight SRAM for the LSTM datapath: masked registered write pipeline, read-after-write
// bypass on the read port, and a burst sequencer streaming consecutive rows to the MAC array.
module sdfa_sram_burst #(
    parameter int LANES      = 8,
    parameter int W_SIZE_BIT = 14,
    parameter int DEPTH      = 256,
    parameter int ADDR_BIT   = 8
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        WE,
    input  logic [ADDR_BIT-1:0]         ADDR_WRITE,
    input  logic [LANES*W_SIZE_BIT-1:0] DIN,
    input  logic [LANES-1:0]            WMASK,
    input  logic                        EN_M,
    input  logic [ADDR_BIT-1:0]         ADDR,
    input  logic                        BURST_START,
    input  logic [ADDR_BIT-1:0]         BURST_ADDR,
    input  logic [ADDR_BIT:0]           BURST_LEN,
    input  logic                        BURST_READY,
    output logic [LANES*W_SIZE_BIT-1:0] DOUT,
    output logic                        DOUT_VALID,
    output logic                        BUSY,
    output logic                        BURST_DONE
);

    localparam int DW = LANES * W_SIZE_BIT;
    localparam logic [31:0]         DEPTH_U  = 32'(DEPTH);
    localparam logic [ADDR_BIT-1:0] ADDR_ONE = ADDR_BIT'(1);
    localparam logic [ADDR_BIT:0]   CNT_ONE  = (ADDR_BIT + 1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [ADDR_BIT-1:0] addr_q, addr_d;
    logic [ADDR_BIT:0]   cnt, cnt_d;
    logic                done_q, done_d;

    logic                we_q;
    logic [ADDR_BIT-1:0] addr_write_q;
    logic [DW-1:0]       din_q;
    logic [LANES-1:0]    wmask_q;

    logic [DW-1:0]       mem [DEPTH];
    logic [DW-1:0]       mask_bits;
    logic [DW-1:0]       rd_word;
    logic                write_live;
    logic                bypass;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            we_q         <= 1'b1;
            addr_write_q <= '0;
            din_q        <= '0;
            wmask_q      <= '0;
        end else begin
            we_q         <= WE;
            addr_write_q <= ADDR_WRITE;
            din_q        <= DIN;
            wmask_q      <= WMASK;
        end
    end

    // Out-of-range write addresses are dropped, both in the array and in the bypass.
    assign write_live = !we_q && (32'(addr_write_q) < DEPTH_U);

    always_comb begin
        mask_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_bits[i*W_SIZE_BIT +: W_SIZE_BIT] = {W_SIZE_BIT{wmask_q[i]}};
        end
    end

    always_ff @(posedge CLK) begin
        if (write_live) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask_q[i]) begin
                    mem[addr_write_q][i*W_SIZE_BIT +: W_SIZE_BIT] <= din_q[i*W_SIZE_BIT +: W_SIZE_BIT];
                end
            end
        end
    end

    assign rd_word = mem[addr_q];
    assign bypass  = write_live && (addr_write_q == addr_q);
    assign DOUT    = bypass ? ((rd_word & ~mask_bits) | (din_q & mask_bits)) : rd_word;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            addr_q <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
            cnt    <= cnt_d;
            done_q <= done_d;
        end
    end

    // Handshake: a beat transfers on a cycle where DOUT_VALID and BURST_READY are both high;
    // while BURST_READY is low, address and count hold so DOUT presents the same row.
    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        cnt_d   = cnt;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (BURST_START && (BURST_LEN != '0)) begin
                    addr_d  = BURST_ADDR;
                    cnt_d   = BURST_LEN;
                    state_d = RUN;
                end else if (!EN_M) begin
                    addr_d = ADDR;
                end
            end
            RUN: begin
                if (BURST_READY) begin
                    if (cnt == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt - CNT_ONE;
                        addr_d = (32'(addr_q) == DEPTH_U - 32'd1) ? '0 : addr_q + ADDR_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign DOUT_VALID = (state == RUN);
    assign BUSY       = (state == RUN);
    assign BURST_DONE = done_q;

endmodule

// File: tb/tb_sdfa_sram_burst.sv
// Directed bench for sdfa_sram_burst: lane masking, write bypass, burst stall/wrap,
// degenerate bursts and mid-burst reset, with hand-computed expected rows.
module tb_sdfa_sram_burst;

    localparam int LANES = 8;
    localparam int WB    = 14;
    localparam int AB    = 8;
    localparam int DW    = LANES * WB;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          WE = 1'b1;
    logic [AB-1:0] ADDR_WRITE = '0;
    logic [DW-1:0] DIN = '0;
    logic [LANES-1:0] WMASK = '0;
    logic          EN_M = 1'b1;
    logic [AB-1:0] ADDR = '0;
    logic          BURST_START = 1'b0;
    logic [AB-1:0] BURST_ADDR = '0;
    logic [AB:0]   BURST_LEN = '0;
    logic          BURST_READY = 1'b0;
    logic [DW-1:0] DOUT;
    logic          DOUT_VALID;
    logic          BUSY;
    logic          BURST_DONE;

    int n_assert = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] din_v;
    logic [DW-1:0] exp_w;
    logic [5:0]    ready_pat;

    sdfa_sram_burst #(.LANES(LANES), .W_SIZE_BIT(WB), .DEPTH(256), .ADDR_BIT(AB)) dut (
        .CLK(CLK), .RSTN(RSTN), .WE(WE), .ADDR_WRITE(ADDR_WRITE), .DIN(DIN), .WMASK(WMASK),
        .EN_M(EN_M), .ADDR(ADDR), .BURST_START(BURST_START), .BURST_ADDR(BURST_ADDR),
        .BURST_LEN(BURST_LEN), .BURST_READY(BURST_READY), .DOUT(DOUT),
        .DOUT_VALID(DOUT_VALID), .BUSY(BUSY), .BURST_DONE(BURST_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] rep(input logic [WB-1:0] v);
        return {LANES{v}};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [DW-1:0] d, input logic [LANES-1:0] m);
        WE = 1'b0;
        ADDR_WRITE = a;
        DIN = d;
        WMASK = m;
        tick();
        WE = 1'b1;
    endtask

    task automatic start_burst(input logic [AB-1:0] a, input logic [AB:0] len);
        BURST_START = 1'b1;
        BURST_ADDR = a;
        BURST_LEN = len;
        tick();
        BURST_START = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_valid", DW'(DOUT_VALID), DW'(1'b0));
        check("rst_busy", DW'(BUSY), DW'(1'b0));
        check("rst_done", DW'(BURST_DONE), DW'(1'b0));
        tick();
        RSTN = 1'b1;
        tick();

        // Preload rows
        for (int i = 0; i < 4; i++) wr(AB'(i), rep(WB'(i)), 8'hFF);
        wr(8'd254, rep(14'd254), 8'hFF);
        wr(8'd255, rep(14'd255), 8'hFF);
        wr(8'd5, rep(14'h0AAA), 8'hFF);
        wr(8'd9, rep(14'h0123), 8'hFF);
        tick();
        tick();

        // Lane mask
        for (int i = 0; i < LANES; i++) din_v[i*WB +: WB] = WB'(16'h1111 * i);
        wr(8'd5, din_v, 8'b0000_0101);
        EN_M = 1'b0;
        ADDR = 8'd5;
        tick();
        EN_M = 1'b1;
        tick();
        exp_w = {{5{14'h0AAA}}, 14'h2222, 14'h0AAA, 14'h0000};
        check("mask_word", DOUT, exp_w);
        check("mask_lane0", DW'(DOUT[0 +: WB]), DW'(14'h0000));
        check("mask_lane1", DW'(DOUT[WB +: WB]), DW'(14'h0AAA));
        check("mask_lane2", DW'(DOUT[2*WB +: WB]), DW'(14'h2222));

        // Bypass
        EN_M = 1'b0;
        ADDR = 8'd9;
        tick();
        check("byp_before", DOUT, rep(14'h0123));
        WE = 1'b0;
        ADDR_WRITE = 8'd9;
        DIN = rep(14'h1555);
        WMASK = 8'hFF;
        tick();
        WE = 1'b1;
        check("byp_n1", DOUT, rep(14'h1555));
        tick();
        check("byp_n2", DOUT, rep(14'h1555));
        tick();
        check("byp_n3", DOUT, rep(14'h1555));
        WE = 1'b0;
        DIN = rep(14'h3FFF);
        WMASK = 8'h0F;
        tick();
        WE = 1'b1;
        exp_w = {{4{14'h1555}}, {4{14'h3FFF}}};
        check("byp_partial", DOUT, exp_w);
        tick();
        check("byp_partial_commit", DOUT, exp_w);
        EN_M = 1'b1;
        tick();

        // Burst with stalls; restart and single-read attempts during RUN must be ignored
        for (int i = 0; i < 4; i++) exp_q.push_back(rep(WB'(i)));
        ready_pat = 6'b101101;
        start_burst(8'd0, 9'd4);
        check("stall_busy", DW'(BUSY), DW'(1'b1));
        for (int k = 0; k < 6; k++) begin
            BURST_READY = ready_pat[k];
            BURST_START = (k == 1 || k == 2);
            BURST_ADDR  = 8'd200;
            BURST_LEN   = 9'd2;
            EN_M        = !(k >= 1 && k <= 3);
            ADDR        = 8'd50;
            check("stall_valid", DW'(DOUT_VALID), DW'(1'b1));
            check("stall_done_low", DW'(BURST_DONE), DW'(1'b0));
            if (exp_q.size() == 0) begin
                check("stall_extra_beat", DW'(1'b1), DW'(1'b0));
            end else if (BURST_READY) begin
                check("stall_beat", DOUT, exp_q.pop_front());
            end else begin
                check("stall_hold", DOUT, exp_q[0]);
            end
            tick();
        end
        BURST_READY = 1'b0;
        BURST_START = 1'b0;
        EN_M = 1'b1;
        check("stall_q_empty", DW'(exp_q.size()), DW'(0));
        check("stall_done", DW'(BURST_DONE), DW'(1'b1));
        check("stall_busy_end", DW'(BUSY), DW'(1'b0));
        check("stall_valid_end", DW'(DOUT_VALID), DW'(1'b0));
        check("stall_last_addr", DOUT, rep(14'd3));
        tick();
        check("stall_done_pulse", DW'(BURST_DONE), DW'(1'b0));

        // Wrap around the end of the array
        exp_q.push_back(rep(14'd254));
        exp_q.push_back(rep(14'd255));
        exp_q.push_back(rep(14'd0));
        exp_q.push_back(rep(14'd1));
        BURST_READY = 1'b1;
        start_burst(8'd254, 9'd4);
        for (int k = 0; k < 4; k++) begin
            check("wrap_valid", DW'(DOUT_VALID), DW'(1'b1));
            check("wrap_beat", DOUT, exp_q.pop_front());
            tick();
        end
        check("wrap_done", DW'(BURST_DONE), DW'(1'b1));
        check("wrap_busy_end", DW'(BUSY), DW'(1'b0));
        tick();

        // Zero-length burst
        start_burst(8'd0, 9'd0);
        check("len0_busy", DW'(BUSY), DW'(1'b0));
        check("len0_done", DW'(BURST_DONE), DW'(1'b0));
        tick();
        check("len0_done2", DW'(BURST_DONE), DW'(1'b0));

        // Reset mid-burst; BURST_START beats EN_M in the same cycle
        EN_M = 1'b0;
        ADDR = 8'd5;
        start_burst(8'd0, 9'd8);
        EN_M = 1'b1;
        check("rb_beat0", DOUT, rep(14'd0));
        tick();
        check("rb_beat1", DOUT, rep(14'd1));
        tick();
        check("rb_beat2", DOUT, rep(14'd2));
        RSTN = 1'b0;
        #1;
        check("rb_valid", DW'(DOUT_VALID), DW'(1'b0));
        check("rb_busy", DW'(BUSY), DW'(1'b0));
        check("rb_done", DW'(BURST_DONE), DW'(1'b0));
        check("rb_dout", DOUT, rep(14'd0));
        BURST_READY = 1'b0;
        tick();
        tick();
        check("rb_done_hold", DW'(BURST_DONE), DW'(1'b0));
        RSTN = 1'b1;
        tick();
        BURST_READY = 1'b1;
        start_burst(8'd0, 9'd4);
        for (int k = 0; k < 4; k++) begin
            check("post_valid", DW'(DOUT_VALID), DW'(1'b1));
            check("post_beat", DOUT, rep(WB'(k)));
            tick();
        end
        check("post_done", DW'(BURST_DONE), DW'(1'b1));
        BURST_READY = 1'b0;
        EN_M = 1'b0;
        ADDR = 8'd9;
        tick();
        EN_M = 1'b1;
        check("post_row9", DOUT, {{4{14'h1555}}, {4{14'h3FFF}}});
        check("post_done_pulse", DW'(BURST_DONE), DW'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
